least_load_dispatch4: RTL and testbench

//  Issuing side of the per-ID usage-count / min-ID scheme. Accepts jobs on a valid/ready

---
 rtl/lld_pkg.sv | 36 +++
 rtl/min4_sel.sv | 16 +
 rtl/least_load_dispatch4.sv | 144 ++++++++++++++
 tb/tb_least_load_dispatch4.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lld_pkg.sv
// Shared types and the argmin helper for the least-load dispatcher.
package lld_pkg;

   localparam int unsigned N_WORKERS = 4;
   localparam int unsigned CNT_MAX_W = 32;

   typedef logic [1:0]           wid_t;
   typedef logic [CNT_MAX_W-1:0] cnt_ext_t;

   typedef enum logic {
      OREG_EMPTY = 1'b0,
      OREG_FULL  = 1'b1
   } oreg_state_e;

   // Strict less-than keeps the earlier index on a tie.
   function automatic wid_t argmin4(input cnt_ext_t c0, input cnt_ext_t c1,
                                    input cnt_ext_t c2, input cnt_ext_t c3);
      wid_t     best;
      cnt_ext_t best_v;
      best   = 2'd0;
      best_v = c0;
      if (c1 < best_v) begin
         best   = 2'd1;
         best_v = c1;
      end
      if (c2 < best_v) begin
         best   = 2'd2;
         best_v = c2;
      end
      if (c3 < best_v) begin
         best   = 2'd3;
      end
      return best;
   endfunction

endpackage

// File: rtl/min4_sel.sv
// Combinational pick of the worker with the fewest outstanding jobs.
module min4_sel
   import lld_pkg::*;
#(
   parameter int unsigned W = 12
) (
   input  logic [N_WORKERS*W-1:0] cnt,
   output wid_t                   sel
);

   assign sel = argmin4(CNT_MAX_W'(cnt[0*W +: W]),
                        CNT_MAX_W'(cnt[1*W +: W]),
                        CNT_MAX_W'(cnt[2*W +: W]),
                        CNT_MAX_W'(cnt[3*W +: W]));

endmodule

// File: rtl/least_load_dispatch4.sv
// Dispatches jobs to the least-loaded of 4 workers and tracks outstanding counts.
// Define DISPATCH_STATS_EN to add the 32-bit accepted-job counter output `total`.
module least_load_dispatch4
   import lld_pkg::*;
#(
   parameter int unsigned W      = 12,
   parameter int unsigned DATA_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   input  logic [DATA_W-1:0]      in_data,
   output logic                   in_ready,
   output logic                   out_valid,
   output logic [DATA_W-1:0]      out_data,
   output logic [1:0]             out_id,
   input  logic                   out_ready,
   input  logic [N_WORKERS-1:0]   done,
   output logic [N_WORKERS*W-1:0] outst,
   output logic                   err
`ifdef DISPATCH_STATS_EN
   ,
   output logic [31:0]            total
`endif
);

   localparam logic [W-1:0] CNT_FULL = '1;

   oreg_state_e            state_q, state_d;
   logic [DATA_W-1:0]      data_q, data_d;
   wid_t                   id_q, id_d;
   logic [N_WORKERS*W-1:0] cnt_q, cnt_d;
   logic                   err_q, err_d;

   logic [W-1:0]           cnt_arr [N_WORKERS];
   logic [N_WORKERS-1:0]   inc, dec;
   wid_t                   sel;
   logic                   accept;

   min4_sel #(.W(W)) u_min4_sel (
      .cnt (cnt_q),
      .sel (sel)
   );

   always_comb begin
      for (int unsigned k = 0; k < N_WORKERS; k++) begin
         cnt_arr[k] = cnt_q[k*W +: W];
      end
   end

   assign in_ready = ((state_q == OREG_EMPTY) | out_ready) & (cnt_arr[sel] != CNT_FULL);
   assign accept   = in_valid & in_ready;

   // A done arriving with the same worker's dispatch cancels it, even at count 0.
   always_comb begin
      inc = '0;
      dec = '0;
      for (int unsigned k = 0; k < N_WORKERS; k++) begin
         inc[k] = accept & (sel == wid_t'(k));
         dec[k] = done[k] & ((cnt_arr[k] != '0) | inc[k]);
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      for (int unsigned k = 0; k < N_WORKERS; k++) begin
         if (inc[k] & ~dec[k]) begin
            cnt_d[k*W +: W] = cnt_arr[k] + W'(1);
         end else if (dec[k] & ~inc[k]) begin
            cnt_d[k*W +: W] = cnt_arr[k] - W'(1);
         end
         if (done[k] & ~dec[k]) begin
            err_d = 1'b1;
         end
      end
   end

   // Output register FSM: EMPTY/FULL with back-to-back reload.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      id_d    = id_q;
      unique case (state_q)
         OREG_EMPTY: begin
            if (accept) begin
               state_d = OREG_FULL;
               data_d  = in_data;
               id_d    = sel;
            end
         end
         OREG_FULL: begin
            if (accept) begin
               data_d = in_data;
               id_d   = sel;
            end else if (out_ready) begin
               state_d = OREG_EMPTY;
            end
         end
         default: state_d = OREG_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= OREG_EMPTY;
         data_q  <= '0;
         id_q    <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         id_q    <= id_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign out_valid = (state_q == OREG_FULL);
   assign out_data  = data_q;
   assign out_id    = id_q;
   assign outst     = cnt_q;
   assign err       = err_q;

`ifdef DISPATCH_STATS_EN
   logic [31:0] total_q, total_d;

   always_comb begin
      total_d = total_q + 32'(accept);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         total_q <= '0;
      end else begin
         total_q <= total_d;
      end
   end

   assign total = total_q;
`endif

endmodule

// File: tb/tb_least_load_dispatch4.sv
// Bench for least_load_dispatch4: a W=12 and a W=2 instance share stimulus and a reference model.
module tb_least_load_dispatch4;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned WA     = 12;
   localparam int unsigned WB     = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              out_ready;
   logic [3:0]        done;

   logic              rdy_a, ov_a, err_a;
   logic [DATA_W-1:0] od_a;
   logic [1:0]        id_a;
   logic [4*WA-1:0]   outst_a;
   logic              rdy_b, ov_b, err_b;
   logic [DATA_W-1:0] od_b;
   logic [1:0]        id_b;
   logic [4*WB-1:0]   outst_b;
`ifdef DISPATCH_STATS_EN
   logic [31:0]       total_a, total_b;
`endif

   least_load_dispatch4 #(.W(WA), .DATA_W(DATA_W)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_a),
      .out_valid(ov_a), .out_data(od_a), .out_id(id_a), .out_ready(out_ready),
      .done(done), .outst(outst_a), .err(err_a)
`ifdef DISPATCH_STATS_EN
      , .total(total_a)
`endif
   );

   least_load_dispatch4 #(.W(WB), .DATA_W(DATA_W)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_b),
      .out_valid(ov_b), .out_data(od_b), .out_id(id_b), .out_ready(out_ready),
      .done(done), .outst(outst_b), .err(err_b)
`ifdef DISPATCH_STATS_EN
      , .total(total_b)
`endif
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: index 0 models dut_a, index 1 models dut_b.
   int unsigned       m_cnt   [2][4];
   bit                m_ov    [2];
   logic [DATA_W-1:0] m_od    [2];
   int unsigned       m_id    [2];
   bit                m_err   [2];
   int unsigned       m_total [2];

   function automatic int unsigned cap(input int i);
      return (i == 0) ? (2**WA - 1) : (2**WB - 1);
   endfunction

   function automatic int unsigned m_sel(input int i);
      int unsigned best = 0;
      for (int k = 1; k < 4; k++) if (m_cnt[i][k] < m_cnt[i][best]) best = k;
      return best;
   endfunction

   function automatic bit m_rdy(input int i);
      return (!m_ov[i] || out_ready) && (m_cnt[i][m_sel(i)] != cap(i));
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 4; k++) m_cnt[i][k] = 0;
            m_ov[i] = 0; m_od[i] = '0; m_id[i] = 0; m_err[i] = 0; m_total[i] = 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            int unsigned s;
            bit          acc;
            s   = m_sel(i);
            acc = in_valid && m_rdy(i);
            for (int k = 0; k < 4; k++) begin
               bit inc;
               inc = acc && (s == k);
               if (inc && done[k]) begin
                  // dispatch and completion cancel
               end else if (inc) begin
                  m_cnt[i][k] = m_cnt[i][k] + 1;
               end else if (done[k]) begin
                  if (m_cnt[i][k] == 0) m_err[i] = 1;
                  else m_cnt[i][k] = m_cnt[i][k] - 1;
               end
            end
            if (acc) begin
               m_ov[i] = 1; m_od[i] = in_data; m_id[i] = s;
               m_total[i] = m_total[i] + 1;
            end else if (out_ready) begin
               m_ov[i] = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < 2; i++) begin
            logic [63:0] e_outst, a_outst;
            int unsigned wi;
            wi = (i == 0) ? WA : WB;
            e_outst = '0;
            for (int k = 0; k < 4; k++) e_outst = e_outst | (64'(m_cnt[i][k]) << (k * wi));
            a_outst = (i == 0) ? 64'(outst_a) : 64'(outst_b);
            chk($sformatf("out_valid[%0d]", i), 64'((i == 0) ? ov_a : ov_b), 64'(m_ov[i]));
            chk($sformatf("in_ready[%0d]", i), 64'((i == 0) ? rdy_a : rdy_b), 64'(m_rdy(i)));
            chk($sformatf("outst[%0d]", i), a_outst, e_outst);
            chk($sformatf("err[%0d]", i), 64'((i == 0) ? err_a : err_b), 64'(m_err[i]));
            if (m_ov[i]) begin
               chk($sformatf("out_data[%0d]", i), 64'((i == 0) ? od_a : od_b), 64'(m_od[i]));
               chk($sformatf("out_id[%0d]", i), 64'((i == 0) ? id_a : id_b), 64'(m_id[i]));
            end
`ifdef DISPATCH_STATS_EN
            chk($sformatf("total[%0d]", i), 64'((i == 0) ? total_a : total_b), 64'(m_total[i]));
`endif
         end
      end
   end

   task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic r,
                       input logic [3:0] dn);
      in_valid = v; in_data = d; out_ready = r; done = dn;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_valid = 0; in_data = '0; out_ready = 1; done = '0;
      rst_n = 0;
      @(posedge clk);
      #1;
      rst_n = 1;
   endtask

   initial begin
      in_valid = 0; in_data = '0; out_ready = 1; done = '0;
      rst_n = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(ov_a), 64'd0);
      chk("rst_out_data", 64'(od_a), 64'd0);
      chk("rst_out_id", 64'(id_a), 64'd0);
      chk("rst_outst", 64'(outst_a), 64'd0);
      chk("rst_err", 64'(err_a), 64'd0);
      rst_n = 1;

      // 1: round-robin from all-zero counts
      for (int j = 0; j < 4; j++) begin
         step(1, 16'h0100 + 16'(j), 1, 4'b0000);
         chk("t1_id_a", 64'(id_a), 64'(j));
         chk("t1_id_b", 64'(id_b), 64'(j));
      end
      chk("t1_outst_a", 64'(outst_a), 64'h001001001001);
      chk("t1_outst_b", 64'(outst_b), 64'h55);
      step(0, '0, 1, 4'b0000);

      // 2: counts {3,1,1,2}, tie-break to worker 1
      do_reset();
      for (int j = 0; j < 9; j++) step(1, 16'h0200 + 16'(j), 1, 4'b0000);
      step(0, '0, 1, 4'b0110);
      chk("t2_pre_outst_a", 64'(outst_a), 64'h002001001003);
      step(1, 16'h02AA, 1, 4'b0000);
      chk("t2_id_a", 64'(id_a), 64'd1);
      chk("t2_outst_a", 64'(outst_a), 64'h002001002003);
      chk("t2_id_b", 64'(id_b), 64'd1);
      chk("t2_outst_b", 64'(outst_b), 64'h9B);

      // 3: stall for 5 cycles, then back-to-back
      in_valid = 1; in_data = 16'h03C3; out_ready = 0; done = '0;
      #1;
      chk("t3_in_ready", 64'(rdy_a), 64'd0);
      for (int j = 0; j < 5; j++) begin
         @(posedge clk);
         #1;
         chk("t3_hold_data", 64'(od_a), 64'h02AA);
         chk("t3_hold_id", 64'(id_a), 64'd1);
         chk("t3_hold_valid", 64'(ov_a), 64'd1);
      end
      step(1, 16'h03C3, 1, 4'b0000);
      chk("t3_b2b_valid", 64'(ov_a), 64'd1);
      chk("t3_b2b_data", 64'(od_a), 64'h03C3);
      chk("t3_b2b_id", 64'(id_a), 64'd2);
      step(0, '0, 1, 4'b0000);
      chk("t3_drain", 64'(ov_a), 64'd0);

      // 4a: dispatch and done on the same worker cancel
      do_reset();
      for (int j = 0; j < 18; j++) step(1, 16'h0400 + 16'(j), 1, 4'b0000);
      step(1, 16'h04FF, 1, 4'b0100);
      chk("t4_id_a", 64'(id_a), 64'd2);
      chk("t4_outst_a", 64'(outst_a), 64'h004004005005);
      chk("t4_err_a", 64'(err_a), 64'd0);
      step(0, '0, 1, 4'b0000);

      // 4b: done on an idle worker
      do_reset();
      step(1, 16'h04A0, 1, 4'b0001);
      chk("t4_cancel_outst", 64'(outst_a), 64'd0);
      chk("t4_cancel_err", 64'(err_a), 64'd0);
      step(0, '0, 1, 4'b0001);
      chk("t4_err_set", 64'(err_a), 64'd1);
      chk("t4_err_outst", 64'(outst_a), 64'd0);
      step(0, '0, 1, 4'b0000);
      chk("t4_err_sticky", 64'(err_a), 64'd1);

      // 5: narrow instance fills up, then a done frees worker 3
      do_reset();
      for (int j = 0; j < 12; j++) step(1, 16'h0500 + 16'(j), 1, 4'b0000);
      in_valid = 1; in_data = 16'h05DD; out_ready = 1; done = '0;
      #1;
      chk("t5_full_ready_b", 64'(rdy_b), 64'd0);
      chk("t5_ready_a", 64'(rdy_a), 64'd1);
      step(1, 16'h05DD, 1, 4'b1000);
      chk("t5_outst_b", 64'(outst_b), 64'hBF);
      step(1, 16'h05EE, 1, 4'b0000);
      chk("t5_id_b", 64'(id_b), 64'd3);
      chk("t5_data_b", 64'(od_b), 64'h05EE);
      chk("t5_id_a", 64'(id_a), 64'd3);
      step(0, '0, 1, 4'b0000);

      // 6: 10 accepts, then async reset with a held job
      do_reset();
      for (int j = 0; j < 10; j++) step(1, 16'h0600 + 16'(j), 1, 4'b0000);
`ifdef DISPATCH_STATS_EN
      chk("t6_total_a", 64'(total_a), 64'd10);
      chk("t6_total_b", 64'(total_b), 64'd10);
`endif
      step(0, '0, 0, 4'b0000);
      chk("t6_held", 64'(ov_a), 64'd1);
      rst_n = 0;
      #1;
      chk("t6_rst_valid_a", 64'(ov_a), 64'd0);
      chk("t6_rst_valid_b", 64'(ov_b), 64'd0);
      chk("t6_rst_outst_a", 64'(outst_a), 64'd0);
      chk("t6_rst_err_a", 64'(err_a), 64'd0);
`ifdef DISPATCH_STATS_EN
      chk("t6_rst_total", 64'(total_a), 64'd0);
`endif
      out_ready = 1;
      @(posedge clk);
      #1;
      rst_n = 1;
      step(0, '0, 1, 4'b0000);
      step(0, '0, 1, 4'b0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
